// File: rtl/noc_link_arbiter.sv
// noc_link_arbiter: round-robin, packet-locking arbiter sharing one flit link
// between NUM_REQ packetizers. A grant is held from header to tailer so that
// packets never interleave; priority rotates past the requester just served.
// Optional lock watchdog: define NOC_ARB_WATCHDOG_EN.
module noc_link_arbiter #(
  parameter int                NUM_REQ         = 4,
  parameter int                FLIT_W          = 8,
  parameter logic [FLIT_W-1:0] TAIL_FLIT       = 8'hFF,
  parameter int                MAX_LOCK_CYCLES = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ*FLIT_W-1:0]  req_flit,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [FLIT_W-1:0]          out_flit,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       wd_err
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = 8;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t            state_r, state_n;
  logic [ID_W-1:0]   rr_ptr_r, rr_ptr_n;
  logic [ID_W-1:0]   grant_r, grant_n;
  logic [ID_W-1:0]   pick_s, next_ptr_s;
  logic              pick_found_s;
  logic [CNT_W-1:0]  pkt_cnt_r, pkt_cnt_n;
  logic [FLIT_W-1:0] out_flit_r, out_flit_n, sel_flit_s;
  logic              out_valid_r, out_valid_n;
  logic              wd_err_r, wd_err_n;
  logic              link_free_s, xfer_s, wd_trip_s;

  // First valid requester at or above ptr, wrapping; returns {found, index}.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic            found;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;
    found = 1'b0;
    win   = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx   = ID_W'((int'(ptr) + k) % NUM_REQ);
      win   = (!found && valid[idx]) ? idx : win;
      found = found | valid[idx];
    end
    return {found, win};
  endfunction

  assign link_free_s = ~out_valid_r | out_ready;
  assign next_ptr_s  = (grant_r == ID_W'(NUM_REQ - 1)) ? '0 : grant_r + ID_W'(1);
  assign {pick_found_s, pick_s} = rr_pick(req_valid, rr_ptr_r);

  // Select the flit offered by the currently granted requester.
  always_comb begin
    sel_flit_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_flit_s = sel_flit_s |
                   ({FLIT_W{grant_r == ID_W'(i)}} & req_flit[i*FLIT_W +: FLIT_W]);
    end
  end

`ifdef NOC_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(MAX_LOCK_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_r, wd_cnt_n;

  assign wd_trip_s = (wd_cnt_r == WD_W'(MAX_LOCK_CYCLES));

  // Watchdog next value: restart on grant and each transfer, saturate at the limit.
  always_comb begin
    wd_cnt_n = wd_cnt_r;
    if ((state_r == ST_IDLE) || xfer_s) begin
      wd_cnt_n = '0;
    end else if (!wd_trip_s) begin
      wd_cnt_n = wd_cnt_r + WD_W'(1);
    end else begin
      wd_cnt_n = wd_cnt_r;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r <= '0;
    end else begin
      wd_cnt_r <= wd_cnt_n;
    end
  end
`else
  assign wd_trip_s = 1'b0;
`endif

  // Arbitration FSM: next state, handshake and output-register next values.
  always_comb begin
    state_n     = state_r;
    rr_ptr_n    = rr_ptr_r;
    grant_n     = grant_r;
    pkt_cnt_n   = pkt_cnt_r;
    out_flit_n  = out_flit_r;
    out_valid_n = out_valid_r;
    wd_err_n    = wd_err_r;
    req_ready   = '0;
    xfer_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // The previous tailer may still be draining while we arbitrate.
        out_valid_n = out_valid_r & ~out_ready;
        if (pick_found_s) begin
          grant_n   = pick_s;
          pkt_cnt_n = '0;
          state_n   = ST_LOCKED;
        end else begin
          state_n   = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        req_ready = NUM_REQ'(link_free_s & ~wd_trip_s) << grant_r;
        xfer_s    = |(req_ready & req_valid);
        if (xfer_s) begin
          out_flit_n  = sel_flit_s;
          out_valid_n = 1'b1;
          pkt_cnt_n   = (pkt_cnt_r == '1) ? pkt_cnt_r : pkt_cnt_r + CNT_W'(1);
          // The header is never a tailer, even when it carries the tail code.
          if ((pkt_cnt_r != '0) && (sel_flit_s == TAIL_FLIT)) begin
            state_n   = ST_IDLE;
            rr_ptr_n  = next_ptr_s;
            pkt_cnt_n = '0;
          end else begin
            state_n   = ST_LOCKED;
          end
        end
`ifdef NOC_ARB_WATCHDOG_EN
        else if (wd_trip_s && link_free_s) begin
          // Stalled too long: close the packet ourselves and release.
          out_flit_n  = TAIL_FLIT;
          out_valid_n = 1'b1;
          wd_err_n    = 1'b1;
          state_n     = ST_IDLE;
          rr_ptr_n    = next_ptr_s;
          pkt_cnt_n   = '0;
        end
`endif
        else begin
          out_valid_n = out_valid_r & ~out_ready;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      grant_r     <= '0;
      pkt_cnt_r   <= '0;
      out_flit_r  <= '0;
      out_valid_r <= 1'b0;
      wd_err_r    <= 1'b0;
    end else begin
      state_r     <= state_n;
      rr_ptr_r    <= rr_ptr_n;
      grant_r     <= grant_n;
      pkt_cnt_r   <= pkt_cnt_n;
      out_flit_r  <= out_flit_n;
      out_valid_r <= out_valid_n;
      wd_err_r    <= wd_err_n;
    end
  end

  assign out_flit  = out_flit_r;
  assign out_valid = out_valid_r;
  assign grant_id  = grant_r;
  assign busy      = (state_r == ST_LOCKED);
  assign wd_err    = wd_err_r;

endmodule

// File: tb/tb_noc_link_arbiter.sv
// Self-checking bench for noc_link_arbiter: a transaction-level reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_noc_link_arbiter;
  localparam int NR   = 4;
  localparam int FW   = 8;
  localparam int MAXL = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR*FW-1:0] req_flit = '0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [FW-1:0]    out_flit;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [1:0]       grant_id;
  logic             busy;
  logic             wd_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] rq_mem [NR][16];
  int         rq_head [NR];
  int         rq_len [NR];
  logic [7:0] out_log [$];
  logic [7:0] pk [8];

  noc_link_arbiter #(
    .NUM_REQ(NR), .FLIT_W(FW), .TAIL_FLIT(8'hFF), .MAX_LOCK_CYCLES(MAXL)
  ) dut (
    .clk(clk), .rst(rst), .req_flit(req_flit), .req_valid(req_valid),
    .req_ready(req_ready), .out_flit(out_flit), .out_valid(out_valid),
    .out_ready(out_ready), .grant_id(grant_id), .busy(busy), .wd_err(wd_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       locked;
    logic [1:0] g;
    logic [1:0] ptr;
    logic       hdr_seen;
    logic       ov;
    logic [7:0] of;
    logic [7:0] idle_cnt;
    logic       wde;
  } mst_t;

  mst_t m = '0;

  function automatic logic wd_trip(mst_t s);
`ifdef NOC_ARB_WATCHDOG_EN
    return s.locked && (int'(s.idle_cnt) >= MAXL);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [NR-1:0] exp_ready(mst_t s, logic ordy);
    logic [NR-1:0] r = '0;
    if (s.locked && !wd_trip(s) && (!s.ov || ordy)) r[s.g] = 1'b1;
    return r;
  endfunction

  function automatic mst_t m_next(mst_t s, logic [NR-1:0] v, logic [NR*FW-1:0] f, logic ordy);
    mst_t       n = s;
    logic       free = !s.ov || ordy;
    logic       found = 1'b0;
    logic [7:0] fl;
    int         j;
    if (!s.locked) begin
      if (ordy) n.ov = 1'b0;
      for (int k = 0; k < NR; k++) begin
        j = (int'(s.ptr) + k) % NR;
        if (!found && v[j]) begin
          found = 1'b1; n.locked = 1'b1; n.g = 2'(j); n.hdr_seen = 1'b0; n.idle_cnt = 8'd0;
        end
      end
    end else begin
      fl = f[int'(s.g)*FW +: FW];
      if (v[s.g] && free && !wd_trip(s)) begin
        n.of = fl; n.ov = 1'b1; n.idle_cnt = 8'd0;
        if (s.hdr_seen && fl == 8'hFF) begin
          n.locked = 1'b0; n.ptr = 2'((int'(s.g) + 1) % NR); n.hdr_seen = 1'b0;
        end else begin
          n.hdr_seen = 1'b1;
        end
      end else if (wd_trip(s) && free) begin
        n.of = 8'hFF; n.ov = 1'b1; n.wde = 1'b1; n.locked = 1'b0;
        n.ptr = 2'((int'(s.g) + 1) % NR); n.hdr_seen = 1'b0;
      end else begin
        if (ordy) n.ov = 1'b0;
        if (int'(s.idle_cnt) < MAXL) n.idle_cnt = s.idle_cnt + 8'd1;
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model on every rising edge; async reset clears it.
  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= m_next(m, req_valid, req_flit, out_ready);
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(m.ov));
    if (m.ov) check("out_flit", 32'(out_flit), 32'(m.of));
    check("req_ready", 32'(req_ready), 32'(exp_ready(m, out_ready)));
    check("grant_id", 32'(grant_id), 32'(m.g));
    check("busy", 32'(busy), 32'(m.locked));
    check("wd_err", 32'(wd_err), 32'(m.wde));
  end

  // Record every flit the router accepts.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) out_log.push_back(out_flit);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (rq_head[i] < rq_len[i]) begin
        req_valid[i] = 1'b1;
        req_flit[i*FW +: FW] = rq_mem[i][rq_head[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_flit[i*FW +: FW] = 8'h00;
      end
    end
  endtask

  task automatic step();
    logic [NR-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (hs[i]) rq_head[i] = rq_head[i] + 1;
    drive();
    #1;
  endtask

  task automatic load(input int r, input logic [7:0] fl [8], input int n);
    for (int k = 0; k < n; k++) rq_mem[r][rq_len[r] + k] = fl[k];
    rq_len[r] = rq_len[r] + n;
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin rq_head[i] = 0; rq_len[i] = 0; end
    drive();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    out_log.delete();
  endtask

  task automatic run_idle(input string name, input int budget);
    int n = 0;
    step();
    while (!(req_valid == '0 && !busy && !out_valid) && n < budget) begin
      step();
      n++;
    end
    check({name, "_completes"}, 32'(n < budget), 32'd1);
  endtask

  task automatic check_log(input string name, input logic [7:0] e [8], input int n);
    check({name, "_len"}, 32'(out_log.size()), 32'(n));
    for (int k = 0; k < n && k < out_log.size(); k++)
      check($sformatf("%s_flit%0d", name, k), 32'(out_log[k]), 32'(e[k]));
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    for (int i = 0; i < NR; i++) begin rq_head[i] = 0; rq_len[i] = 0; end
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_flit", 32'(out_flit), 32'd0);
    check("reset_grant_id", 32'(grant_id), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_wd_err", 32'(wd_err), 32'd0);
    rst = 1'b0;
    #1;

    // Basic packet from requester 2, with grant latency.
    out_log.delete();
    pk = '{8'hBD, 8'h11, 8'h22, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    load(2, pk, 4);
    check("basic_idle_ready", 32'(req_ready), 32'd0);
    check("basic_idle_busy", 32'(busy), 32'd0);
    step();
    check("basic_grant", 32'(grant_id), 32'd2);
    check("model_grant", 32'(m.g), 32'd2);
    check("basic_ready_n1", 32'(req_ready), 32'h4);
    check("basic_no_out_n1", 32'(out_valid), 32'd0);
    step();
    check("basic_out_valid_n2", 32'(out_valid), 32'd1);
    check("basic_hdr_n2", 32'(out_flit), 32'hBD);
    check("model_hdr_n2", 32'(m.of), 32'hBD);
    run_idle("basic", 20);
    check_log("basic", pk, 4);
    check("basic_busy_end", 32'(busy), 32'd0);

    // Round-robin across requesters 0,1,3 with 2-flit packets.
    do_reset();
    pk = '{8'hBC, 8'hFF, 8'hBC, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    load(0, pk, 4);
    pk = '{8'hBD, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load(1, pk, 2);
    pk = '{8'hBF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load(3, pk, 2);
    run_idle("rr", 40);
    pk = '{8'hBC, 8'hFF, 8'hBD, 8'hFF, 8'hBF, 8'hFF, 8'hBC, 8'hFF};
    check_log("rr", pk, 8);

    // Header equal to the tail code must not end the packet.
    out_log.delete();
    pk = '{8'hFF, 8'h05, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load(1, pk, 3);
    step();
    check("hdrff_grant", 32'(grant_id), 32'd1);
    step();
    check("hdrff_still_busy", 32'(busy), 32'd1);
    check("hdrff_ready", 32'(req_ready), 32'h2);
    run_idle("hdrff", 20);
    check_log("hdrff", pk, 3);

    // Back-pressure for 4 cycles mid-packet.
    out_log.delete();
    pk = '{8'hBC, 8'h01, 8'h02, 8'h03, 8'hFF, 8'h00, 8'h00, 8'h00};
    load(0, pk, 5);
    step();
    step();
    step();
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      check("bp_flit_hold", 32'(out_flit), 32'h01);
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_ready_zero", 32'(req_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    run_idle("bp", 20);
    check_log("bp", pk, 5);

    // Reset in the middle of a packet; arbitration restarts at requester 0.
    pk = '{8'hBE, 8'h11, 8'h22, 8'h33, 8'hFF, 8'h00, 8'h00, 8'h00};
    load(2, pk, 5);
    step();
    check("midrst_grant", 32'(grant_id), 32'd2);
    step();
    step();
    check("midrst_busy_before", 32'(busy), 32'd1);
    do_reset();
    pk = '{8'hBC, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load(0, pk, 2);
    pk = '{8'hBD, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load(1, pk, 2);
    step();
    check("postrst_grant", 32'(grant_id), 32'd0);
    check("model_postrst_grant", 32'(m.g), 32'd0);
    run_idle("postrst", 30);
    pk = '{8'hBC, 8'hFF, 8'hBD, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    check_log("postrst", pk, 4);

`ifdef NOC_ARB_WATCHDOG_EN
    // Requester 0 stalls after its header; watchdog closes the packet.
    out_log.delete();
    pk = '{8'hBC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load(0, pk, 1);
    pk = '{8'hBD, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load(1, pk, 2);
    run_idle("wd", 40);
    check("wd_err_set", 32'(wd_err), 32'd1);
    pk = '{8'hBC, 8'hFF, 8'hBD, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    check_log("wd", pk, 4);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_link_arbiter.md
# noc_link_arbiter

Round-robin, packet-locking arbiter that lets several network-interface packetizers share one 8-bit router injection link. Each requester offers a flit stream (header flit `101111dd`, data flits, tailer `0xFF`) over valid/ready. The arbiter grants one requester, holds that grant from header to tailer so packets never interleave, then rotates priority. It sits between the per-processor NI send paths and the router input port.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; 2..8.
- `FLIT_W`, default 8: flit width in bits.
- `TAIL_FLIT`, default 8'hFF: tailer code that ends a packet.
- `MAX_LOCK_CYCLES`, default 32: watchdog limit. Used only when `NOC_ARB_WATCHDOG_EN` is defined.

Ports:
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_flit` in NUM_REQ*FLIT_W: requester i drives bits [i*FLIT_W +: FLIT_W].
- `req_valid` in NUM_REQ: requester i is offering a flit.
- `req_ready` out NUM_REQ: one-hot or zero. Bit i high means requester i's flit is taken this cycle.
- `out_flit` out FLIT_W: registered flit to the router.
- `out_valid` out 1: `out_flit` is valid.
- `out_ready` in 1: router accepts `out_flit` this cycle.
- `grant_id` out clog2(NUM_REQ): current or last granted requester.
- `busy` out 1: high while in LOCKED.
- `wd_err` out 1: sticky watchdog flag. Tied 0 without the macro.

## Operation
- **Reset values:** every output 0, state IDLE, round-robin pointer `rr_ptr` 0, flit counter 0.
- **States:** IDLE, LOCKED.
- **IDLE:**
  - `req_ready` is all 0.
  - If any `req_valid` is high, pick the first set bit searching from `rr_ptr` upward, wrapping modulo NUM_REQ.
  - Register the winner in `grant_id`, then move to LOCKED.
- **LOCKED, granted requester g:**
  - `req_ready[g] = ~out_valid | out_ready`. All other bits are 0.
  - A transfer occurs when `req_valid[g] & req_ready[g]`. On a transfer, `out_flit` takes the flit, `out_valid` goes to 1, and `pkt_cnt` increments.
  - If no transfer occurs and `out_ready` is high, `out_valid` goes to 0.
- **First flit:** the first flit after grant (`pkt_cnt` 0) is the header. It is never treated as the tailer, whatever its value.
- **Packet end:** a transferred flit equal to `TAIL_FLIT` with `pkt_cnt` ≥ 1 ends the packet:
  - state returns to IDLE;
  - `rr_ptr` becomes (g+1) mod NUM_REQ;
  - `pkt_cnt` clears.
- **Protocol rule:** data flits never equal `TAIL_FLIT`. The NI packetizer guarantees this.
- **Requester stall:** if `req_valid[g]` drops mid-packet, the arbiter stays locked to g and waits. No other requester is served.
- **Non-granted requesters:** they hold their flits until they are granted. The arbiter imposes no ordering among them other than round-robin.
- **`grant_id`:** holds its value in IDLE until the next grant.

## Timing
- **Grant latency:** `req_valid` rises in IDLE in cycle n. Grant is registered at the edge ending cycle n. `req_ready[g]` is high in cycle n+1, and the first flit is on `out_valid` in cycle n+2.
- **Throughput:** one flit per cycle while `out_ready` stays high. A packet of k flits occupies the link for k cycles, plus 1 IDLE arbitration cycle between packets.
- **Back-pressure:** with `out_valid`=1 and `out_ready`=0, `out_flit` and `out_valid` hold and `req_ready` is 0.
- **Tailer and next packet:** the last flit is accepted in cycle m (tailer). IDLE arbitration happens in cycle m+1, and the next packet's header can be accepted in cycle m+2. The tailer drains from the output register in parallel.
- **Asynchronous reset mid-packet:** drops `out_valid` and `req_ready` immediately. The partial packet is lost, and requesters must restart.

## Configuration
- **`NOC_ARB_WATCHDOG_EN` defined:**
  - A counter runs while LOCKED. It clears on grant and on every transfer.
  - When it reaches `MAX_LOCK_CYCLES`, `req_ready` is forced to 0.
  - At the next cycle where `~out_valid | out_ready`, the arbiter injects `TAIL_FLIT` itself, sets `wd_err` to 1 (sticky until `rst`), and releases to IDLE with the normal `rr_ptr` update.
- **`NOC_ARB_WATCHDOG_EN` undefined:** no counter. The lock is held indefinitely, and `wd_err` is constant 0.

## Test plan
- **Basic packet:** after reset, req 2 sends BD,11,22,FF with `out_ready`=1 → `grant_id`=2; `out_flit` shows BD,11,22,FF on consecutive cycles; first `out_valid` in cycle 2 after `req_valid`; `busy` falls after FF.
- **Round-robin:** reqs 0,1,3 all valid with 2-flit packets → served in order 0,1,3,0. No flits interleave inside any packet.
- **Header equal to FF:** req 1 sends header FF, then 05, FF → treated as 3 flits, and the lock releases only after the second FF.
- **Back-pressure:** `out_ready` low for 4 cycles mid-packet → `out_flit` is stable, `req_ready` is 0 throughout, and no flit is lost or duplicated.
- **Reset mid-packet:** assert `rst` after 2 flits → `out_valid`, `busy` and `req_ready` are 0 immediately. After release, the next grant starts from requester 0.
- **Watchdog (macro on, `MAX_LOCK_CYCLES`=8):** req 0 sends header, then stalls → after 8 cycles `out_flit`=FF, `wd_err`=1, and a pending req 1 is granted next.
